// File: rtl/gcd_axil_engine.sv
// -----------------------------------------------------------------------------
// gcd_axil_engine
//
// AXI4-Lite slave that wraps a binary (Stein) GCD engine. Software loads two
// operands, pulses CTRL.start, then polls STATUS.done or takes the level
// interrupt. A cycle counter reports how long the last computation took.
//
// Register map (word index = byte address[4:2]):
//   0 CTRL    bit0 start (write-1, self-clearing, reads 0), bit1 ie (RW)
//   1 STATUS  bit0 busy (RO), bit1 done (write-1-to-clear)
//   2 OP_A    RW, OPERAND_W bits, upper bits read 0
//   3 OP_B    RW, OPERAND_W bits, upper bits read 0
//   4 RESULT  RO
//   5 CYCLES  RO, 32-bit
//   6,7       unmapped (SLVERR)
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   S_AXI_AW* / W* / B*    AXI4-Lite write address, data and response channels
//   S_AXI_AR* / R*         AXI4-Lite read address and data channels
//   irq                    level interrupt = STATUS.done & CTRL.ie
// -----------------------------------------------------------------------------
module gcd_axil_engine #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int OPERAND_W          = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int NBYTES = DW / 8;
    localparam int KW     = $clog2(OPERAND_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_STATUS = 3'd1;
    localparam logic [2:0] IDX_OPA    = 3'd2;
    localparam logic [2:0] IDX_OPB    = 3'd3;
    localparam logic [2:0] IDX_RESULT = 3'd4;
    localparam logic [2:0] IDX_CYCLES = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_REDUCE
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_reg,   state_next;
    logic [OPERAND_W-1:0]   a_reg,       a_next;
    logic [OPERAND_W-1:0]   b_reg,       b_next;
    logic [KW-1:0]          k_reg,       k_next;
    logic [OPERAND_W-1:0]   result_reg,  result_next;
    logic [31:0]            cycles_reg,  cycles_next;
    logic                   done_reg,    done_next;
    logic                   ie_reg,      ie_next;
    logic [OPERAND_W-1:0]   op_a_reg,    op_a_next;
    logic [OPERAND_W-1:0]   op_b_reg,    op_b_next;

    // AWREADY and WREADY always move together, so one register drives both.
    logic                   awready_reg, awready_next;
    logic                   bvalid_reg,  bvalid_next;
    logic [1:0]             bresp_reg,   bresp_next;
    logic                   arready_reg, arready_next;
    logic                   rvalid_reg,  rvalid_next;
    logic [1:0]             rresp_reg,   rresp_next;
    logic [DW-1:0]          rdata_reg,   rdata_next;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [2:0]     wr_idx;
    logic [2:0]     rd_idx;
    logic           wr_fire;
    logic           rd_fire;
    logic           busy;
    logic           wr_err;
    logic           rd_err;
    logic           start_req;
    logic [DW-1:0]  rd_word;
    logic [DW-1:0]  op_a_ext;
    logic [DW-1:0]  op_b_ext;
    logic [DW-1:0]  merge_a;
    logic [DW-1:0]  merge_b;
    logic [OPERAND_W-1:0] diff_ab;
    logic [OPERAND_W-1:0] diff_ba;

    assign wr_idx  = S_AXI_AWADDR[4:2];
    assign rd_idx  = S_AXI_ARADDR[4:2];
    assign wr_fire = awready_reg & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire = arready_reg & S_AXI_ARVALID;
    assign busy    = (state_reg != S_IDLE);

    // Indices 4..7 are either read-only or unmapped: never writable.
    // Operand writes during a computation are refused so the software view
    // of OP_A/OP_B always matches what the engine latched.
    assign wr_err = (wr_idx >= IDX_RESULT) ||
                    (((wr_idx == IDX_OPA) || (wr_idx == IDX_OPB)) && busy);
    assign rd_err = (rd_idx > IDX_CYCLES);

    assign start_req = wr_fire && (wr_idx == IDX_CTRL) &&
                       S_AXI_WSTRB[0] && S_AXI_WDATA[0];

    assign op_a_ext = DW'(op_a_reg);
    assign op_b_ext = DW'(op_b_reg);
    assign diff_ab  = a_reg - b_reg;
    assign diff_ba  = b_reg - a_reg;

    // Byte-lane merge of write data with the current operand value.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign merge_a[gi*8 +: 8] = S_AXI_WSTRB[gi] ? S_AXI_WDATA[gi*8 +: 8]
                                                        : op_a_ext[gi*8 +: 8];
            assign merge_b[gi*8 +: 8] = S_AXI_WSTRB[gi] ? S_AXI_WDATA[gi*8 +: 8]
                                                        : op_b_ext[gi*8 +: 8];
        end
    endgenerate

    // Inputs with no function here (protection bits, byte offset, merge bits
    // above OPERAND_W when the operand is narrow).
    logic unused_inputs;
    assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR, S_AXI_ARADDR, merge_a, merge_b};

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        case (rd_idx)
            IDX_CTRL:   rd_word = DW'({ie_reg, 1'b0});
            IDX_STATUS: rd_word = DW'({done_reg, busy});
            IDX_OPA:    rd_word = op_a_ext;
            IDX_OPB:    rd_word = op_b_ext;
            IDX_RESULT: rd_word = DW'(result_reg);
            IDX_CYCLES: rd_word = DW'(cycles_reg);
            default:    rd_word = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // AXI handshakes
    // ------------------------------------------------------------------
    always_comb begin
        // Ready pulses for exactly one cycle and is never raised while a
        // response is still outstanding.
        awready_next = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_reg & ~awready_reg;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        arready_next = S_AXI_ARVALID & ~rvalid_reg & ~arready_reg;
        rvalid_next  = rvalid_reg;
        rresp_next   = rresp_reg;
        rdata_next   = rdata_reg;

        if (wr_fire) begin
            bvalid_next = 1'b1;
            bresp_next  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_reg && S_AXI_BREADY) begin
            bvalid_next = 1'b0;
        end

        if (rd_fire) begin
            rvalid_next = 1'b1;
            rdata_next  = rd_word;
            rresp_next  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register writes and GCD engine next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        k_next      = k_reg;
        result_next = result_reg;
        cycles_next = cycles_reg;
        done_next   = done_reg;
        ie_next     = ie_reg;
        op_a_next   = op_a_reg;
        op_b_next   = op_b_reg;

        if (wr_fire && (wr_idx == IDX_CTRL) && S_AXI_WSTRB[0]) begin
            ie_next = S_AXI_WDATA[1];
        end
        if (wr_fire && (wr_idx == IDX_OPA) && !busy) begin
            op_a_next = merge_a[OPERAND_W-1:0];
        end
        if (wr_fire && (wr_idx == IDX_OPB) && !busy) begin
            op_b_next = merge_b[OPERAND_W-1:0];
        end
        // W1C goes first so that a completion in the same cycle overrides it.
        if (wr_fire && (wr_idx == IDX_STATUS) && S_AXI_WDATA[1]) begin
            done_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (start_req) begin
                    a_next      = op_a_reg;
                    b_next      = op_b_reg;
                    k_next      = '0;
                    cycles_next = 32'd0;
                    done_next   = 1'b0;
                    if ((op_a_reg == '0) || (op_b_reg == '0)) begin
                        // gcd(x,0) = x: finish in the start cycle itself.
                        result_next = op_a_reg | op_b_reg;
                        done_next   = 1'b1;
                        cycles_next = 32'd1;
                    end else begin
                        state_next = S_ALIGN;
                    end
                end
            end

            S_ALIGN: begin
                cycles_next = cycles_reg + 32'd1;
                // Strip common factors of two; they are restored via k.
                if (!a_reg[0] && !b_reg[0]) begin
                    a_next = a_reg >> 1;
                    b_next = b_reg >> 1;
                    k_next = k_reg + KW'(1);
                end else begin
                    state_next = S_REDUCE;
                end
            end

            S_REDUCE: begin
                cycles_next = cycles_reg + 32'd1;
                if (a_reg == b_reg) begin
                    result_next = a_reg << k_reg;
                    done_next   = 1'b1;
                    state_next  = S_IDLE;
                end else if (!a_reg[0]) begin
                    a_next = a_reg >> 1;
                end else if (!b_reg[0]) begin
                    b_next = b_reg >> 1;
                end else if (a_reg > b_reg) begin
                    // Both odd: the difference is even, so halve it at once.
                    a_next = diff_ab >> 1;
                end else begin
                    b_next = diff_ba >> 1;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg   <= S_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            k_reg       <= '0;
            result_reg  <= '0;
            cycles_reg  <= '0;
            done_reg    <= 1'b0;
            ie_reg      <= 1'b0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            k_reg       <= k_next;
            result_reg  <= result_next;
            cycles_reg  <= cycles_next;
            done_reg    <= done_next;
            ie_reg      <= ie_next;
            op_a_reg    <= op_a_next;
            op_b_reg    <= op_b_next;
            awready_reg <= awready_next;
            bvalid_reg  <= bvalid_next;
            bresp_reg   <= bresp_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
            rresp_reg   <= rresp_next;
            rdata_reg   <= rdata_next;
        end
    end

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = awready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign irq           = done_reg & ie_reg;

endmodule

// File: tb/tb_gcd_axil_engine.sv
// -----------------------------------------------------------------------------
// tb_gcd_axil_engine
//
// Directed bench for gcd_axil_engine. Expected AXI responses are pushed to
// scoreboard queues when a transaction is issued and popped when the DUT
// answers. Expected GCD values come from a Euclidean reference function.
// -----------------------------------------------------------------------------
module tb_gcd_axil_engine;

    localparam int TIMEOUT = 100;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_STATUS = 5'h04;
    localparam logic [4:0] A_OPA    = 5'h08;
    localparam logic [4:0] A_OPB    = 5'h0C;
    localparam logic [4:0] A_RESULT = 5'h10;
    localparam logic [4:0] A_CYCLES = 5'h14;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        irq;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [1:0]  wq[$];
    logic [33:0] rq[$];

    always #5 ACLK = ~ACLK;

    gcd_axil_engine #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .OPERAND_W          (32)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .irq           (irq)
    );

    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input int hold, input string tag);
        int n;
        logic [1:0] exp;
        wq.push_back(exp_resp);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!(awready && wready) && n < TIMEOUT);
        if (!(awready && wready)) check({tag, "_aw_timeout"}, 32'd0, 32'd1);
        @(posedge ACLK); #1;
        if (hold == 0) begin awvalid = 1'b0; wvalid = 1'b0; end
        n = 0;
        do begin @(negedge ACLK); n++; end while (!bvalid && n < TIMEOUT);
        if (!bvalid) check({tag, "_b_timeout"}, 32'd0, 32'd1);
        exp = wq.pop_front();
        check({tag, "_bresp"}, 32'(bresp), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            check({tag, "_bhold"}, 32'({bvalid, awready, wready, bresp}),
                  32'({1'b1, 1'b0, 1'b0, exp}));
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge ACLK); #1;
        bready = 1'b0;
        $display("WR %-12s addr=0x%02h data=0x%08h strb=0x%h bresp=%0d",
                 tag, addr, data, strb, bresp);
    endtask

    task automatic axi_read(input logic [4:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!arready && n < TIMEOUT);
        if (!arready) check("ar_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        if (hold == 0) arvalid = 1'b0;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!rvalid && n < TIMEOUT);
        if (!rvalid) check("r_timeout", 32'd0, 32'd1);
        data = rdata;
        resp = rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            if (rq.size() > 0) begin
                check("rhold_data", rdata, rq[0][31:0]);
                check("rhold_ctl", 32'({rvalid, arready, rresp}),
                      32'({1'b1, 1'b0, rq[0][33:32]}));
            end
        end
        arvalid = 1'b0; rready = 1'b1;
        @(posedge ACLK); #1;
        rready = 1'b0;
        $display("RD addr=0x%02h data=0x%08h rresp=%0d", addr, data, resp);
    endtask

    task automatic read_chk(input logic [4:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold, input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        logic [33:0] e;
        rq.push_back({exp_resp, exp_data});
        axi_read(addr, hold, d, r);
        e = rq.pop_front();
        check({tag, "_data"}, d, e[31:0]);
        check({tag, "_resp"}, 32'(r), 32'(e[33:32]));
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        n = 0;
        do begin axi_read(A_STATUS, 0, d, r); n++; end while (!d[1] && n < 300);
        if (!d[1]) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_gcd(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ctrl, input string tag);
        axi_write(A_OPA, a, 4'hF, OKAY, 0, {tag, "_opa"});
        axi_write(A_OPB, b, 4'hF, OKAY, 0, {tag, "_opb"});
        axi_write(A_CTRL, ctrl, 4'hF, OKAY, 0, {tag, "_start"});
        wait_done(tag);
        read_chk(A_RESULT, ref_gcd(a, b), OKAY, 0, {tag, "_result"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_outputs", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, irq}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        for (int i = 0; i < 6; i++) read_chk(5'(i * 4), 32'd0, OKAY, 0, "rst_reg");
        read_chk(5'h18, 32'd0, SLVERR, 0, "unmapped_rd");

        // 12, 18 with interrupt enabled
        axi_write(A_OPA, 32'd12, 4'hF, OKAY, 0, "opa12");
        axi_write(A_OPB, 32'd18, 4'hF, OKAY, 0, "opb18");
        axi_write(A_CTRL, 32'h3, 4'hF, OKAY, 0, "start_ie");
        read_chk(A_STATUS, 32'h1, OKAY, 0, "busy");
        wait_done("g12_18");
        read_chk(A_STATUS, 32'h2, OKAY, 0, "status_done");
        read_chk(A_RESULT, ref_gcd(32'd12, 32'd18), OKAY, 0, "res12_18");
        read_chk(A_CYCLES, 32'd5, OKAY, 0, "cyc12_18");
        read_chk(A_CTRL, 32'h2, OKAY, 0, "ctrl_rd");
        check("irq_high", 32'(irq), 32'd1);
        axi_write(A_STATUS, 32'h2, 4'hF, OKAY, 0, "w1c_done");
        check("irq_low", 32'(irq), 32'd0);
        read_chk(A_STATUS, 32'h0, OKAY, 0, "status_clr");

        // Zero operands (interrupt disabled by CTRL=1)
        run_gcd(32'd0, 32'd35, 32'h1, "z0_35");
        read_chk(A_CYCLES, 32'd1, OKAY, 0, "cyc_zero");
        check("irq_masked", 32'(irq), 32'd0);
        run_gcd(32'd0, 32'd0, 32'h1, "z0_0");

        // Wide operands
        run_gcd(32'h8000_0000, 32'hC000_0000, 32'h3, "big_pow2");
        read_chk(A_CYCLES, 32'd34, OKAY, 0, "cyc_pow2");
        check("irq_big", 32'(irq), 32'd1);
        run_gcd(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, "all_ones");

        // Writes while busy: operand refused, restart ignored
        axi_write(A_OPA, 32'h8000_0000, 4'hF, OKAY, 0, "opa_b");
        axi_write(A_OPB, 32'hC000_0000, 4'hF, OKAY, 0, "opb_b");
        axi_write(A_CTRL, 32'h1, 4'hF, OKAY, 0, "start_b");
        axi_write(A_OPA, 32'd7, 4'hF, SLVERR, 0, "opa_busy");
        read_chk(A_OPA, 32'h8000_0000, OKAY, 0, "opa_rd_busy");
        axi_write(A_CTRL, 32'h1, 4'hF, OKAY, 0, "restart");
        read_chk(A_STATUS, 32'h1, OKAY, 0, "still_busy");
        wait_done("busy_run");
        read_chk(A_RESULT, 32'h4000_0000, OKAY, 0, "res_busy");
        read_chk(A_CYCLES, 32'd34, OKAY, 0, "cyc_norestart");

        // Read-only and unmapped writes
        axi_write(A_RESULT, 32'h1234, 4'hF, SLVERR, 0, "ro_result");
        axi_write(5'h1C, 32'h1, 4'hF, SLVERR, 0, "unmapped_wr");
        read_chk(A_RESULT, 32'h4000_0000, OKAY, 0, "res_ro");

        // Reset during a computation
        axi_write(A_CTRL, 32'h3, 4'hF, OKAY, 0, "start_rst");
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check("midrst_outputs", 32'({awready, bvalid, arready, rvalid, irq}), 32'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        read_chk(A_STATUS, 32'h0, OKAY, 0, "rst_status");
        read_chk(A_RESULT, 32'h0, OKAY, 0, "rst_result");
        read_chk(A_OPA, 32'h0, OKAY, 0, "rst_opa");

        // Stalled responses
        axi_write(A_OPB, 32'h55, 4'hF, OKAY, 5, "bhold");
        read_chk(A_OPB, 32'h55, OKAY, 5, "rhold");

        // Byte strobes
        axi_write(A_OPA, 32'h1122_3344, 4'hF, OKAY, 0, "opa_full");
        axi_write(A_OPA, 32'h0000_00AB, 4'h1, OKAY, 0, "opa_byte");
        read_chk(A_OPA, 32'h1122_33AB, OKAY, 0, "strb_opa");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/gcd_axil_engine.md
Name: gcd_axil_engine

Overview:
- Parametrised successor to the fixed 4-register GCD AXI4-Lite peripheral.
- Adds operand width as a parameter, a binary (Stein) GCD engine with a start/busy/done control model, a cycle counter, a W1C done flag with level interrupt, and SLVERR reporting.
- Sits behind the PS AXI interconnect as a memory-mapped slave; software loads the operands, starts the engine, then polls or takes the interrupt.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte-address width; covers 8 word slots.
- OPERAND_W, 32, operand/result width; legal range 8..32, upper register bits read 0.

Ports:
- ACLK in 1: sole clock.
- ARESETN in 1: asynchronous assert, active-low reset.
- S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- irq out 1: level interrupt, equal to STATUS.done & CTRL.ie.

Behaviour:
- Reset: all AXI outputs 0; irq 0; all registers 0; FSM IDLE.
- Register map (word index = addr[4:2]):
  - 0 CTRL: bit0 start (W1, self-clearing, reads 0); bit1 ie (RW).
  - 1 STATUS: bit0 busy (RO); bit1 done (W1C).
  - 2 OP_A: RW.
  - 3 OP_B: RW.
  - 4 RESULT: RO.
  - 5 CYCLES: RO, 32-bit.
  - 6, 7: unmapped.
- Write channel:
  - Accept only when AWVALID & WVALID are both high and BVALID is 0.
  - On accept, AWREADY and WREADY pulse high for one cycle; BVALID rises the next cycle and holds until BREADY.
  - WSTRB masks bytes for OP_A, OP_B, CTRL.
- Read channel:
  - Accept when ARVALID is high and RVALID is 0.
  - ARREADY pulses for one cycle; RVALID and RDATA appear the next cycle and hold until RREADY.
- Responses:
  - BRESP/RRESP = OKAY (00) normally.
  - SLVERR (10) for an unmapped address.
  - SLVERR for a write to OP_A or OP_B while busy; the write is dropped.
  - SLVERR for a write to a RO register; no effect.
- FSM: IDLE -> ALIGN -> REDUCE -> IDLE.
  - IDLE:
    - start=1 latches a = OP_A[OPERAND_W-1:0], b = OP_B, k = 0, CYCLES = 0; sets busy = 1; clears done.
    - If a==0 or b==0: RESULT = a|b, done = 1, return to IDLE (CYCLES = 1).
    - Otherwise go to ALIGN.
  - ALIGN, one step per cycle: while a[0]==0 and b[0]==0, shift both right by 1 and k++; otherwise go to REDUCE.
  - REDUCE, one step per cycle, in priority order:
    - a==b: RESULT = a<<k, done = 1, busy = 0, go to IDLE.
    - a even: a >>= 1.
    - b even: b >>= 1.
    - a>b: a = (a-b)>>1.
    - else: b = (b-a)>>1.
  - CYCLES increments every cycle while busy, counting from the first cycle after start.
  - Subtraction is OPERAND_W-bit unsigned; it never underflows because of the compare.
- Boundary conditions:
  - start while busy: ignored, response OKAY.
  - A CTRL write with start=1 and a same-cycle done W1C: start wins and done ends at 0.
  - done setting in the same cycle as a W1C of done: set wins.
  - OP_A/OP_B readback returns the written value even while busy.
  - ARESETN low mid-computation: immediate return to reset state; RESULT = 0.
  - AXI read and write may complete in the same cycle independently.

Test Plan:
- Reset then read all 6 registers -> all 0, RRESP OKAY; read 0x18 -> SLVERR, RDATA 0.
- Write OP_A=12, OP_B=18, CTRL=0x3 -> busy=1 next cycle; STATUS reaches 0x2 with RESULT=6; irq rises with done; W1C STATUS=0x2 -> irq falls.
- OP_A=0, OP_B=35, start -> RESULT=35, CYCLES=1; OP_A=0, OP_B=0 -> RESULT=0.
- OP_A=0x80000000, OP_B=0xC0000000 -> RESULT=0x40000000.
- OP_A=0xFFFFFFFF, OP_B=0xFFFFFFFE -> RESULT=1.
- During busy, write OP_A=7 -> BRESP SLVERR and RESULT unaffected.
- During busy, write start -> no restart.
- During busy, assert ARESETN low for 2 cycles -> STATUS=0, RESULT=0.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and data held stable, no second accept.
- Byte write WSTRB=0x1, WDATA=0xAB to OP_A=0x11223344 -> OP_A reads 0x112233AB.
